// File: rtl/fib_table.sv
// fib_table: NDN FIB stage -- deframes SPI packets toward the PIT and frames PIT requests back onto SPI
module fib_table #(
  parameter int PREFIX_W  = 64,
  parameter int META_W    = 8,
  parameter int PAYLOAD_B = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PREFIX_W-1:0] pit_in_prefix,
  input  logic [META_W-1:0]   pit_in_metadata,
  input  logic                rejected,
  input  logic                fib_out_bit,
  input  logic                start_send_to_pit,
  input  logic [7:0]          data_PIT_to_FIB,
  input  logic                RX_valid,
  input  logic [7:0]          data_SPI_to_FIB,
  output logic [PREFIX_W-1:0] pit_out_prefix,
  output logic                prefix_ready,
  output logic [META_W-1:0]   pit_out_metadata,
  output logic [7:0]          data_FIB_to_PIT,
  output logic                FIB_to_SPI_data_flag,
  output logic [7:0]          data_FIB_to_SPI
);
  localparam int HDR_W = META_W + PREFIX_W;
  localparam int HDR_B = HDR_W / 8;
  localparam int PKT_B = HDR_B + PAYLOAD_B;
  localparam int PW    = $clog2(PAYLOAD_B);
  typedef enum logic [2:0] {I_IDLE, I_HDR, I_PAY, I_ANN, I_CHECK, I_TOPIT} in_st_e;
  typedef enum logic [2:0] {O_IDLE, O_WAIT, O_RXPIT, O_FLAG, O_TX} out_st_e;
  in_st_e      in_st_q;
  out_st_e     out_st_q;
  logic [5:0]  in_cnt_q, out_cnt_q;
  logic [HDR_W-1:0] rx_hdr_q, tx_hdr_q, rx_hdr_d;
  logic [7:0]  in_buf_q  [PAYLOAD_B];
  logic [7:0]  out_buf_q [PAYLOAD_B];
  logic [7:0]  tx_pkt_d  [PKT_B];
  logic [5:0]  tx_last_d;
  // header as it will look once the byte on the SPI bus is shifted in; lets the last header byte announce directly
  always_comb begin
    rx_hdr_d = (in_st_q == I_HDR) ? {rx_hdr_q[HDR_W-9:0], data_SPI_to_FIB} : rx_hdr_q;
  end
  // outbound packet laid out byte by byte: metadata, prefix MSB first, then payload
  always_comb begin
    for (int k = 0; k < HDR_B; k++) tx_pkt_d[k] = tx_hdr_q[HDR_W-1-8*k -: 8];
    for (int k = 0; k < PAYLOAD_B; k++) tx_pkt_d[HDR_B+k] = out_buf_q[k];
    tx_last_d = tx_hdr_q[HDR_W-1] ? 6'(PKT_B-1) : 6'(HDR_B-1);
  end
  // inbound FSM: collect header and payload, announce to the PIT, then stream payload unless rejected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_st_q          <= I_IDLE;
      in_cnt_q         <= '0;
      rx_hdr_q         <= '0;
      in_buf_q         <= '{default: '0};
      pit_out_prefix   <= '0;
      pit_out_metadata <= '0;
      prefix_ready     <= 1'b0;
      data_FIB_to_PIT  <= '0;
    end else begin
      prefix_ready <= 1'b0;
      case (in_st_q)
        I_IDLE: begin
          in_cnt_q <= '0;
          if (RX_valid) in_st_q <= I_HDR;
        end
        I_HDR: begin
          rx_hdr_q <= rx_hdr_d;
          in_cnt_q <= in_cnt_q + 6'd1;
          if (in_cnt_q == 6'(HDR_B-1)) begin
            in_cnt_q <= '0;
            if (rx_hdr_d[HDR_W-1]) in_st_q <= I_PAY;
            else begin
              in_st_q          <= I_ANN;
              prefix_ready     <= 1'b1;
              pit_out_metadata <= rx_hdr_d[HDR_W-1 -: META_W];
              pit_out_prefix   <= rx_hdr_d[PREFIX_W-1:0];
            end
          end
        end
        I_PAY: begin
          in_buf_q[in_cnt_q[PW-1:0]] <= data_SPI_to_FIB;
          in_cnt_q <= in_cnt_q + 6'd1;
          if (in_cnt_q == 6'(PAYLOAD_B-1)) begin
            in_st_q          <= I_ANN;
            prefix_ready     <= 1'b1;
            pit_out_metadata <= rx_hdr_d[HDR_W-1 -: META_W];
            pit_out_prefix   <= rx_hdr_d[PREFIX_W-1:0];
          end
        end
        I_ANN: in_st_q <= I_CHECK;
        I_CHECK: begin
          if (rejected || !pit_out_metadata[META_W-1]) in_st_q <= I_IDLE;
          else begin
            in_st_q         <= I_TOPIT;
            data_FIB_to_PIT <= in_buf_q[0];
            in_cnt_q        <= 6'd1;
          end
        end
        I_TOPIT: begin
          data_FIB_to_PIT <= in_buf_q[in_cnt_q[PW-1:0]];
          in_cnt_q        <= in_cnt_q + 6'd1;
          if (in_cnt_q == 6'(PAYLOAD_B-1)) in_st_q <= I_IDLE;
        end
        default: in_st_q <= I_IDLE;
      endcase
    end
  end
  // outbound FSM: latch PIT request, optionally gather payload, then flag and serialize onto SPI
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_st_q             <= O_IDLE;
      out_cnt_q            <= '0;
      tx_hdr_q             <= '0;
      out_buf_q            <= '{default: '0};
      FIB_to_SPI_data_flag <= 1'b0;
      data_FIB_to_SPI      <= '0;
    end else begin
      FIB_to_SPI_data_flag <= 1'b0;
      case (out_st_q)
        O_IDLE: begin
          out_cnt_q <= '0;
          if (fib_out_bit) begin
            tx_hdr_q <= {pit_in_metadata, pit_in_prefix};
            if (pit_in_metadata[META_W-1]) out_st_q <= O_WAIT;
            else begin
              out_st_q             <= O_FLAG;
              FIB_to_SPI_data_flag <= 1'b1;
            end
          end
        end
        O_WAIT: if (start_send_to_pit) out_st_q <= O_RXPIT;
        O_RXPIT: begin
          out_buf_q[out_cnt_q[PW-1:0]] <= data_PIT_to_FIB;
          out_cnt_q <= out_cnt_q + 6'd1;
          if (out_cnt_q == 6'(PAYLOAD_B-1)) begin
            out_cnt_q            <= '0;
            out_st_q             <= O_FLAG;
            FIB_to_SPI_data_flag <= 1'b1;
          end
        end
        O_FLAG, O_TX: begin
          data_FIB_to_SPI <= tx_pkt_d[out_cnt_q];
          out_cnt_q       <= out_cnt_q + 6'd1;
          out_st_q        <= (out_cnt_q == tx_last_d) ? O_IDLE : O_TX;
        end
        default: out_st_q <= O_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fib_table.sv
// tb_fib_table: randomized self-checking bench for the FIB stage against a packet-level model
module tb_fib_table;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pit_in_prefix;
  logic [7:0]  pit_in_metadata;
  logic        rejected, fib_out_bit, start_send_to_pit, RX_valid;
  logic [7:0]  data_PIT_to_FIB, data_SPI_to_FIB;
  logic [63:0] pit_out_prefix;
  logic        prefix_ready, FIB_to_SPI_data_flag;
  logic [7:0]  pit_out_metadata, data_FIB_to_PIT, data_FIB_to_SPI;
  int vecs = 0;
  int errs = 0;
  logic [7:0] in_pkt  [41];
  logic [7:0] out_pkt [41];
  int in_len, out_len;

  fib_table dut (
    .clk(clk), .rst(rst),
    .pit_in_prefix(pit_in_prefix), .pit_in_metadata(pit_in_metadata),
    .rejected(rejected), .fib_out_bit(fib_out_bit), .start_send_to_pit(start_send_to_pit),
    .data_PIT_to_FIB(data_PIT_to_FIB), .RX_valid(RX_valid), .data_SPI_to_FIB(data_SPI_to_FIB),
    .pit_out_prefix(pit_out_prefix), .prefix_ready(prefix_ready), .pit_out_metadata(pit_out_metadata),
    .data_FIB_to_PIT(data_FIB_to_PIT), .FIB_to_SPI_data_flag(FIB_to_SPI_data_flag),
    .data_FIB_to_SPI(data_FIB_to_SPI)
  );

  always #5 clk = ~clk;

  task automatic make_pkt(input bit dir_out, input logic [7:0] meta, input logic [63:0] pre,
                          input bit ramp, input logic [7:0] base);
    logic [7:0] p [41];
    p[0] = meta;
    for (int k = 0; k < 8; k++) p[1+k] = pre[63-8*k -: 8];
    for (int k = 0; k < 32; k++) p[9+k] = ramp ? base + 8'(k) : 8'($urandom);
    if (dir_out) begin
      out_pkt = p;
      out_len = meta[7] ? 41 : 9;
    end else begin
      in_pkt = p;
      in_len = meta[7] ? 41 : 9;
    end
  endtask

  task automatic run_in(input bit rej);
    logic [7:0]  held;
    logic [63:0] exp_pre;
    exp_pre = '0;
    for (int k = 1; k < 9; k++) exp_pre = {exp_pre[55:0], in_pkt[k]};
    held = data_FIB_to_PIT;
    RX_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < in_len; k++) begin
      RX_valid = (k > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      rejected = 1'($urandom);
      data_SPI_to_FIB = in_pkt[k];
      @(negedge clk);
      vecs++;
      if (prefix_ready !== (k == in_len - 1))
        begin errs++; $display("FAIL in_prefix_ready byte %0d got %b exp %b", k, prefix_ready, k == in_len - 1); end
    end
    RX_valid = 1'b0;
    rejected = 1'b0;
    data_SPI_to_FIB = 8'($urandom);
    vecs++;
    if (pit_out_metadata !== in_pkt[0])
      begin errs++; $display("FAIL in_meta got %h exp %h", pit_out_metadata, in_pkt[0]); end
    vecs++;
    if (pit_out_prefix !== exp_pre)
      begin errs++; $display("FAIL in_prefix got %h exp %h", pit_out_prefix, exp_pre); end
    @(negedge clk);
    vecs++;
    if (prefix_ready !== 1'b0)
      begin errs++; $display("FAIL in_ready_width got %b exp 0", prefix_ready); end
    rejected = rej;
    @(negedge clk);
    rejected = 1'($urandom);
    if (in_pkt[0][7] && !rej) begin
      for (int j = 0; j < 32; j++) begin
        vecs++;
        if (data_FIB_to_PIT !== in_pkt[9+j])
          begin errs++; $display("FAIL to_pit byte %0d got %h exp %h", j, data_FIB_to_PIT, in_pkt[9+j]); end
        @(negedge clk);
      end
      vecs++;
      if (data_FIB_to_PIT !== in_pkt[40])
        begin errs++; $display("FAIL to_pit_hold got %h exp %h", data_FIB_to_PIT, in_pkt[40]); end
    end else begin
      for (int j = 0; j < 34; j++) begin
        vecs++;
        if (data_FIB_to_PIT !== held)
          begin errs++; $display("FAIL to_pit_idle cycle %0d got %h exp %h", j, data_FIB_to_PIT, held); end
        @(negedge clk);
      end
    end
    rejected = 1'b0;
  endtask

  task automatic run_out(input int gap);
    pit_in_metadata = out_pkt[0];
    for (int k = 1; k < 9; k++) pit_in_prefix = {pit_in_prefix[55:0], out_pkt[k]};
    fib_out_bit = 1'b1;
    @(negedge clk);
    fib_out_bit = 1'b0;
    pit_in_metadata = 8'($urandom);
    pit_in_prefix = {$urandom, $urandom};
    if (out_pkt[0][7]) begin
      for (int g = 0; g < gap; g++) begin
        fib_out_bit = 1'($urandom);
        data_PIT_to_FIB = 8'($urandom);
        @(negedge clk);
        vecs++;
        if (FIB_to_SPI_data_flag !== 1'b0)
          begin errs++; $display("FAIL out_wait_flag got %b exp 0", FIB_to_SPI_data_flag); end
      end
      fib_out_bit = 1'b0;
      start_send_to_pit = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 32; j++) begin
        start_send_to_pit = (j > 0) ? 1'($urandom) : 1'b0;
        data_PIT_to_FIB = out_pkt[9+j];
        @(negedge clk);
        vecs++;
        if (FIB_to_SPI_data_flag !== (j == 31))
          begin errs++; $display("FAIL out_rx_flag byte %0d got %b exp %b", j, FIB_to_SPI_data_flag, j == 31); end
      end
      start_send_to_pit = 1'b0;
      data_PIT_to_FIB = 8'($urandom);
    end else begin
      vecs++;
      if (FIB_to_SPI_data_flag !== 1'b1)
        begin errs++; $display("FAIL out_flag got %b exp 1", FIB_to_SPI_data_flag); end
    end
    for (int k = 0; k < out_len; k++) begin
      fib_out_bit = 1'($urandom);
      start_send_to_pit = 1'($urandom);
      @(negedge clk);
      vecs++;
      if (data_FIB_to_SPI !== out_pkt[k] || FIB_to_SPI_data_flag !== 1'b0)
        begin errs++; $display("FAIL out_byte %0d got %h/%b exp %h/0", k, data_FIB_to_SPI, FIB_to_SPI_data_flag, out_pkt[k]); end
    end
    fib_out_bit = 1'b0;
    start_send_to_pit = 1'b0;
    @(negedge clk);
    vecs++;
    if (data_FIB_to_SPI !== out_pkt[out_len-1] || FIB_to_SPI_data_flag !== 1'b0)
      begin errs++; $display("FAIL out_hold got %h/%b exp %h/0", data_FIB_to_SPI, FIB_to_SPI_data_flag, out_pkt[out_len-1]); end
  endtask

  task automatic test_reset;
    pit_in_prefix = '0; pit_in_metadata = '0; rejected = 0; fib_out_bit = 0;
    start_send_to_pit = 0; data_PIT_to_FIB = '0; RX_valid = 0; data_SPI_to_FIB = '0;
    rst = 1'b1;
    #100;
    vecs++;
    if ({pit_out_prefix, prefix_ready, pit_out_metadata, data_FIB_to_PIT, FIB_to_SPI_data_flag, data_FIB_to_SPI} !== '0)
      begin errs++; $display("FAIL reset_outputs got %h exp 0", {pit_out_prefix, prefix_ready, pit_out_metadata,
        data_FIB_to_PIT, FIB_to_SPI_data_flag, data_FIB_to_SPI}); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      data_SPI_to_FIB = 8'($urandom);
      @(negedge clk);
      vecs++;
      if (prefix_ready !== 1'b0 || pit_out_metadata !== 8'h00)
        begin errs++; $display("FAIL idle_quiet cycle %0d got %b/%h exp 0/00", c, prefix_ready, pit_out_metadata); end
    end
  endtask

  task automatic test_interest_in;
    make_pkt(1'b0, 8'h30, 64'h0000FFFF0000FFFF, 1'b1, 8'h00);
    run_in(1'b0);
  endtask

  task automatic test_data_in;
    make_pkt(1'b0, 8'h80, 64'h0123456789ABCDEF, 1'b1, 8'h00);
    run_in(1'b0);
  endtask

  task automatic test_rejected;
    make_pkt(1'b0, 8'h9C, {$urandom, $urandom}, 1'b0, 8'h00);
    run_in(1'b1);
    make_pkt(1'b0, 8'h11, {$urandom, $urandom}, 1'b0, 8'h00);
    run_in(1'b0);
  endtask

  task automatic test_interest_out;
    make_pkt(1'b1, 8'h30, 64'hDEADBEEF00112233, 1'b1, 8'h00);
    run_out(0);
  endtask

  task automatic test_concurrent;
    make_pkt(1'b0, 8'h42, 64'hCAFEF00D12345678, 1'b1, 8'h00);
    make_pkt(1'b1, 8'h81, 64'h1122334455667788, 1'b1, 8'hA0);
    fork
      run_in(1'b0);
      run_out(3);
    join
  endtask

  task automatic test_mid_reset;
    make_pkt(1'b0, 8'h85, {$urandom, $urandom}, 1'b0, 8'h00);
    pit_in_metadata = 8'h30;
    pit_in_prefix = {$urandom, $urandom};
    RX_valid = 1'b1;
    fib_out_bit = 1'b1;
    @(negedge clk);
    RX_valid = 1'b0;
    fib_out_bit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data_SPI_to_FIB = in_pkt[k];
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if ({pit_out_prefix, prefix_ready, pit_out_metadata, data_FIB_to_PIT, FIB_to_SPI_data_flag, data_FIB_to_SPI} !== '0)
      begin errs++; $display("FAIL mid_reset_outputs got %h exp 0", {pit_out_prefix, prefix_ready, pit_out_metadata,
        data_FIB_to_PIT, FIB_to_SPI_data_flag, data_FIB_to_SPI}); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 45; c++) begin
      data_SPI_to_FIB = in_pkt[(c + 4) % 41];
      @(negedge clk);
      vecs++;
      if (prefix_ready !== 1'b0 || FIB_to_SPI_data_flag !== 1'b0 || data_FIB_to_SPI !== 8'h00)
        begin errs++; $display("FAIL mid_reset_quiet cycle %0d got %b/%b/%h exp 0/0/00", c, prefix_ready,
          FIB_to_SPI_data_flag, data_FIB_to_SPI); end
    end
    make_pkt(1'b0, 8'h07, {$urandom, $urandom}, 1'b0, 8'h00);
    make_pkt(1'b1, 8'h0F, {$urandom, $urandom}, 1'b0, 8'h00);
    fork
      run_in(1'b0);
      run_out(0);
    join
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      make_pkt(1'b0, 8'($urandom), {$urandom, $urandom}, 1'b0, 8'h00);
      make_pkt(1'b1, 8'($urandom), {$urandom, $urandom}, 1'b0, 8'h00);
      fork
        run_in(1'($urandom_range(0, 3) == 0));
        run_out(int'($urandom_range(0, 5)));
      join
    end
  endtask

  initial begin
    test_reset();
    test_interest_in();
    test_data_in();
    test_rejected();
    test_interest_out();
    test_concurrent();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
